md_issue_ctrl: RTL

- E-stage initiator for the multiply/divide unit. It registers the MD-class opcode from D into E and drives Start, MDSel, A and B toward the MD unit.
- Selects HI/LO for mfhi/mflo and generates the D-stage stall for any MD-class instruction while an MD operation is outstanding.
- Keeps its own cycle-accurate model of MD occupancy so the stall does not depend solely on the MD Busy output.

---
 rtl/md_issue_ctrl_pkg.sv | 56 +++++
 rtl/md_issue_ctrl_if.sv | 15 +
 rtl/md_issue_ctrl_occupancy_model.sv | 57 +++++
 rtl/md_issue_ctrl.sv | 71 +++++++
 4 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared MD-unit definitions: operation select codes, MD-class opcodes and
// occupancy FSM states, plus the opcode classification helpers.
package md_issue_ctrl_pkg;

  localparam int WIDTH_MDSEL = 3;
  localparam int WIDTH_MDOP  = 4;

  typedef enum logic [WIDTH_MDSEL-1:0] {
    MDSEL_NONE  = 3'd0,
    MDSEL_MULT  = 3'd1,
    MDSEL_MULTU = 3'd2,
    MDSEL_DIV   = 3'd3,
    MDSEL_DIVU  = 3'd4,
    MDSEL_MTHI  = 3'd5,
    MDSEL_MTLO  = 3'd6
  } mdsel_t;

  typedef enum logic [WIDTH_MDOP-1:0] {
    MDOP_NONE  = 4'd0,
    MDOP_MULT  = 4'd1,
    MDOP_MULTU = 4'd2,
    MDOP_DIV   = 4'd3,
    MDOP_DIVU  = 4'd4,
    MDOP_MTHI  = 4'd5,
    MDOP_MTLO  = 4'd6,
    MDOP_MFHI  = 4'd7,
    MDOP_MFLO  = 4'd8
  } mdop_t;

  typedef enum logic [1:0] {
    OCC_IDLE = 2'd0,
    OCC_MUL  = 2'd1,
    OCC_DIV  = 2'd2
  } occ_state_t;

  function automatic mdsel_t mdop2sel(input mdop_t op);
    case (op)
      MDOP_MULT:  return MDSEL_MULT;
      MDOP_MULTU: return MDSEL_MULTU;
      MDOP_DIV:   return MDSEL_DIV;
      MDOP_DIVU:  return MDSEL_DIVU;
      MDOP_MTHI:  return MDSEL_MTHI;
      MDOP_MTLO:  return MDSEL_MTLO;
      default:    return MDSEL_NONE;
    endcase
  endfunction

  function automatic logic is_mul(input mdop_t op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU);
  endfunction

  function automatic logic is_div(input mdop_t op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Issue-side bus toward the multiply/divide unit.
interface md_issue_ctrl_if;
  import md_issue_ctrl_pkg::*;

  logic                   Start;
  logic [WIDTH_MDSEL-1:0] MDSel;
  logic [31:0]            A;
  logic [31:0]            B;
  logic                   Busy;
  logic [31:0]            HI;
  logic [31:0]            LO;

  modport master (output Start, MDSel, A, B, input Busy, HI, LO);
  modport slave  (input Start, MDSel, A, B, output Busy, HI, LO);
endinterface

// File: rtl/md_issue_ctrl_occupancy_model.sv
// Cycle-accurate shadow of MD occupancy: busy from the Start cycle through
// MUL_CYCLES / DIV_CYCLES further cycles.
module md_occupancy_model
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic StartMul,
  input  logic StartDiv,
  output logic modelBusy
);

  occ_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= OCC_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      OCC_IDLE: begin
        if (StartMul) begin
          state_nxt = OCC_MUL;
          cnt_nxt   = CNT_W'(MUL_CYCLES);
        end else if (StartDiv) begin
          state_nxt = OCC_DIV;
          cnt_nxt   = CNT_W'(DIV_CYCLES);
        end
      end
      default: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = OCC_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
    endcase
  end

  // The Start cycle itself is busy, before the FSM has left IDLE.
  assign modelBusy = (state != OCC_IDLE) | StartMul | StartDiv;

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage MD initiator: registers the MD opcode, issues Start/MDSel/A/B,
// muxes HI/LO for mfhi/mflo and stalls D behind an outstanding MD op.
// Optional Busy cross-check against the shadow model: MD_BUSY_CHECK_EN.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [WIDTH_MDOP-1:0] MDOpD,
  input  logic                  FlushE,
  input  logic [31:0]           RsE,
  input  logic [31:0]           RtE,
  md_issue_ctrl_if.master       md,
  output logic [31:0]           MDOutE,
  output logic                  StallD,
  output logic                  ErrFlag
);

  mdop_t MDOpE;
  logic  start_mul, start_div, start_mt;
  logic  modelBusy;

  // A stall turns E into a bubble; E itself never holds.
  always_ff @(posedge Clk) begin
    if (Reset || FlushE || StallD) MDOpE <= MDOP_NONE;
    else                           MDOpE <= mdop_t'(MDOpD);
  end

  assign start_mul = !FlushE & is_mul(MDOpE);
  assign start_div = !FlushE & is_div(MDOpE);
  assign start_mt  = !FlushE & ((MDOpE == MDOP_MTHI) | (MDOpE == MDOP_MTLO));

  assign md.Start = start_mul | start_div | start_mt;
  assign md.MDSel = mdop2sel(MDOpE);
  assign md.A     = RsE;
  assign md.B     = RtE;

  always_comb begin
    MDOutE = '0;
    if (MDOpE == MDOP_MFHI)      MDOutE = md.HI;
    else if (MDOpE == MDOP_MFLO) MDOutE = md.LO;
  end

  md_occupancy_model #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) u_occ (
    .Clk      (Clk),
    .Reset    (Reset),
    .StartMul (start_mul),
    .StartDiv (start_div),
    .modelBusy(modelBusy)
  );

  assign StallD = (MDOpD != MDOP_NONE) & (modelBusy | md.Busy);

`ifdef MD_BUSY_CHECK_EN
  always_ff @(posedge Clk) begin
    if (Reset)                        ErrFlag <= 1'b0;
    else if (md.Busy != modelBusy)    ErrFlag <= 1'b1;
  end
`else
  assign ErrFlag = 1'b0;
`endif

endmodule
